// File: rtl/moore_seq_gen_pkg.sv
// Shared types and constants for the moore_seq_gen serial pattern generator.
// Holds the FSM state encoding, default widths, the detector pattern and the parity helper.
package moore_seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } gen_state_e;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 4;

    // Pattern recognised by the companion overlapping Moore detector
    localparam logic [3:0] DET_PATTERN = 4'b1011;

    function automatic logic even_parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/moore_seq_gen_piso.sv
// Loadable parallel-in/serial-out shift register, MSB first.
// Exposes the MSB the register will hold after the coming edge so the owner can register it.
module seq_piso #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_msb_nxt
);

    logic [W-1:0] r_sr;

    // Shift register: load has priority over shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= {W{1'b0}};
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= {r_sr[W-2:0], 1'b0};
        end else begin
            r_sr <= r_sr;
        end
    end

    // Look-ahead MSB
    always_comb begin
        if (i_load) begin
            o_msb_nxt = i_data[W-1];
        end else if (i_shift) begin
            o_msb_nxt = r_sr[W-2];
        end else begin
            o_msb_nxt = r_sr[W-1];
        end
    end

endmodule

// File: rtl/moore_seq_gen.sv
// Moore serial pattern generator: shifts a latched pattern out MSB-first for R repetitions.
// Optional per-repetition even-parity bit enabled by defining MOORE_SEQ_GEN_PARITY_EN.
module moore_seq_gen
    import moore_seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep_in,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int               BW       = $clog2(PAT_W);
    localparam logic [BW-1:0]    BIT_TOP  = BW'(PAT_W - 1);
    localparam logic [BW-1:0]    BIT_ZERO = {BW{1'b0}};
    localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_PAR   = PAR;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]       r_state;
    logic [BW-1:0]    r_bit_cnt;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [PAT_W-1:0] r_pat;
    logic             r_out;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [BW-1:0]    w_bit_nxt;
    logic [CNT_W-1:0] w_rep_nxt;
    logic [PAT_W-1:0] w_pat_nxt;
    logic             w_load;
    logic             w_shift;
    logic [PAT_W-1:0] w_load_data;
    logic             w_msb_nxt;
    logic             w_out_nxt;
    logic             w_valid_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    seq_piso #(
        .W(PAT_W)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_shift   (w_shift),
        .i_data    (w_load_data),
        .o_msb_nxt (w_msb_nxt)
    );

    // Next-state, counter and shift-register control
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_rep_nxt   = r_rep_cnt;
        w_pat_nxt   = r_pat;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_load_data = r_pat;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                    w_load      = 1'b1;
                    w_load_data = pat_in;
                    w_pat_nxt   = pat_in;
                    w_rep_nxt   = (rep_in == {CNT_W{1'b0}}) ? REP_ONE : rep_in;
                    w_bit_nxt   = BIT_TOP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_bit_cnt != BIT_ZERO) begin
                    w_shift   = 1'b1;
                    w_bit_nxt = r_bit_cnt - BW'(1);
                end else begin
`ifdef MOORE_SEQ_GEN_PARITY_EN
                    w_state_nxt = ST_PAR;
`else
                    // Reload for the next repetition with no gap cycle
                    if (r_rep_cnt > REP_ONE) begin
                        w_load    = 1'b1;
                        w_rep_nxt = r_rep_cnt - REP_ONE;
                        w_bit_nxt = BIT_TOP;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
`endif
                end
            end
            ST_PAR: begin
`ifdef MOORE_SEQ_GEN_PARITY_EN
                if (r_rep_cnt > REP_ONE) begin
                    w_state_nxt = ST_SHIFT;
                    w_load      = 1'b1;
                    w_rep_nxt   = r_rep_cnt - REP_ONE;
                    w_bit_nxt   = BIT_TOP;
                end else begin
                    w_state_nxt = ST_DONE;
                end
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they can be registered without latency
    always_comb begin
        w_out_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (w_state_nxt)
            ST_SHIFT: begin
                w_out_nxt   = w_msb_nxt;
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
            end
`ifdef MOORE_SEQ_GEN_PARITY_EN
            ST_PAR: begin
                w_out_nxt   = even_parity(32'(r_pat));
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
            end
`endif
            ST_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_out_nxt = 1'b0;
            end
        endcase
    end

    // State, counters, latched pattern and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= BIT_ZERO;
            r_rep_cnt <= {CNT_W{1'b0}};
            r_pat     <= {PAT_W{1'b0}};
            r_out     <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_rep_cnt <= w_rep_nxt;
            r_pat     <= w_pat_nxt;
            r_out     <= w_out_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign out   = r_out;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_moore_seq_gen.sv
// Directed self-checking bench for moore_seq_gen; expectations switch with MOORE_SEQ_GEN_PARITY_EN.
// Captured cycle index i corresponds to the cycle after edge k+i where k is the accepting edge.
module tb_moore_seq_gen;
    import moore_seq_gen_pkg::*;

    localparam int PW = PAT_W_DEF;
    localparam int CW = CNT_W_DEF;

`ifdef MOORE_SEQ_GEN_PARITY_EN
    localparam logic [31:0] SGL_OUT = {7'b1011100, 25'd0};
    localparam logic [31:0] SGL_VAL = {7'b1111100, 25'd0};
    localparam logic [31:0] SGL_DON = {7'b0000010, 25'd0};
    localparam int          SGL_N   = 7;
    localparam logic [31:0] R2_OUT  = {12'b101111011100, 20'd0};
    localparam logic [31:0] R2_VAL  = {12'b111111111100, 20'd0};
    localparam logic [31:0] R2_DON  = {12'b000000000010, 20'd0};
    localparam int          R2_N    = 12;
    localparam logic [15:0] R2_DET  = 16'h0210;
    localparam logic [31:0] IG_OUT  = {8'b10111000, 24'd0};
    localparam logic [31:0] IG_BSY  = {8'b11111000, 24'd0};
    localparam logic [31:0] IG_DON  = {8'b00000100, 24'd0};
    localparam int          IG_N    = 8;
    localparam int          IG_HOLD = 5;
    localparam logic [31:0] BB_OUT  = {14'b10111001011100, 18'd0};
    localparam logic [31:0] BB_DON  = {14'b00000100000100, 18'd0};
    localparam int          BB_N    = 14;
    localparam logic [31:0] RN_OUT  = {7'b0110000, 25'd0};
    localparam logic [31:0] RN_VAL  = {7'b1111100, 25'd0};
    localparam logic [31:0] RN_DON  = {7'b0000010, 25'd0};
`else
    localparam logic [31:0] SGL_OUT = {6'b101100, 26'd0};
    localparam logic [31:0] SGL_VAL = {6'b111100, 26'd0};
    localparam logic [31:0] SGL_DON = {6'b000010, 26'd0};
    localparam int          SGL_N   = 6;
    localparam logic [31:0] R2_OUT  = {10'b1011101100, 22'd0};
    localparam logic [31:0] R2_VAL  = {10'b1111111100, 22'd0};
    localparam logic [31:0] R2_DON  = {10'b0000000010, 22'd0};
    localparam int          R2_N    = 10;
    localparam logic [15:0] R2_DET  = 16'h0110;
    localparam logic [31:0] IG_OUT  = {7'b1011000, 25'd0};
    localparam logic [31:0] IG_BSY  = {7'b1111000, 25'd0};
    localparam logic [31:0] IG_DON  = {7'b0000100, 25'd0};
    localparam int          IG_N    = 7;
    localparam int          IG_HOLD = 4;
    localparam logic [31:0] BB_OUT  = {12'b101100101100, 20'd0};
    localparam logic [31:0] BB_DON  = {12'b000010000010, 20'd0};
    localparam int          BB_N    = 12;
    localparam logic [31:0] RN_OUT  = {6'b011000, 26'd0};
    localparam logic [31:0] RN_VAL  = {6'b111100, 26'd0};
    localparam logic [31:0] RN_DON  = {6'b000010, 26'd0};
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic [PW-1:0] pat_in;
    logic [CW-1:0] rep_in;
    logic          out;
    logic          valid;
    logic          busy;
    logic          done;

    logic [31:0] cap_out;
    logic [31:0] cap_val;
    logic [31:0] cap_bsy;
    logic [31:0] cap_don;
    logic [15:0] det_pos;
    logic [3:0]  det_hist;
    int          bit_no;
    int          n_cmp;
    int          n_bad;

    moore_seq_gen #(
        .PAT_W(PW),
        .CNT_W(CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .pat_in (pat_in),
        .rep_in (rep_in),
        .out    (out),
        .valid  (valid),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start pulse; returns in the first cycle after the accepting edge
    task automatic fire(input logic [PW-1:0] p, input logic [CW-1:0] r);
        cap_out  = 32'd0;
        cap_val  = 32'd0;
        cap_bsy  = 32'd0;
        cap_don  = 32'd0;
        det_pos  = 16'd0;
        det_hist = 4'd0;
        bit_no   = 0;
        pat_in   = p;
        rep_in   = r;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Record outputs and feed an overlapping 1011 detector model, one cycle per step
    task automatic capture(input int off, input int n);
        for (int i = 0; i < n; i++) begin
            cap_out[31-(off+i)] = out;
            cap_val[31-(off+i)] = valid;
            cap_bsy[31-(off+i)] = busy;
            cap_don[31-(off+i)] = done;
            if (valid === 1'b1) begin
                bit_no   = bit_no + 1;
                det_hist = {det_hist[2:0], out};
                if (det_hist == DET_PATTERN && bit_no < 16) det_pos[bit_no] = 1'b1;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (out !== 1'b0)   begin n_bad++; $display("FAIL reset_out got %b exp 0", out); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", valid); end
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
    endtask

    task automatic test_single();
        fire(4'b1011, 4'd1);
        capture(0, SGL_N);
        n_cmp++; if (cap_out !== SGL_OUT) begin n_bad++; $display("FAIL single_out got %b exp %b", cap_out, SGL_OUT); end
        n_cmp++; if (cap_val !== SGL_VAL) begin n_bad++; $display("FAIL single_valid got %b exp %b", cap_val, SGL_VAL); end
        n_cmp++; if (cap_bsy !== SGL_VAL) begin n_bad++; $display("FAIL single_busy got %b exp %b", cap_bsy, SGL_VAL); end
        n_cmp++; if (cap_don !== SGL_DON) begin n_bad++; $display("FAIL single_done got %b exp %b", cap_don, SGL_DON); end
    endtask

    task automatic test_rep2_detect();
        fire(4'b1011, 4'd2);
        capture(0, R2_N);
        n_cmp++; if (cap_out !== R2_OUT) begin n_bad++; $display("FAIL rep2_out got %b exp %b", cap_out, R2_OUT); end
        n_cmp++; if (cap_val !== R2_VAL) begin n_bad++; $display("FAIL rep2_valid got %b exp %b", cap_val, R2_VAL); end
        n_cmp++; if (cap_bsy !== R2_VAL) begin n_bad++; $display("FAIL rep2_busy got %b exp %b", cap_bsy, R2_VAL); end
        n_cmp++; if (cap_don !== R2_DON) begin n_bad++; $display("FAIL rep2_done got %b exp %b", cap_don, R2_DON); end
        n_cmp++; if (det_pos !== R2_DET) begin n_bad++; $display("FAIL rep2_detect got %h exp %h", det_pos, R2_DET); end
    endtask

    task automatic test_rep_zero();
        fire(4'b1011, 4'd0);
        capture(0, SGL_N);
        n_cmp++; if (cap_out !== SGL_OUT) begin n_bad++; $display("FAIL rep0_out got %b exp %b", cap_out, SGL_OUT); end
        n_cmp++; if (cap_val !== SGL_VAL) begin n_bad++; $display("FAIL rep0_valid got %b exp %b", cap_val, SGL_VAL); end
        n_cmp++; if (cap_don !== SGL_DON) begin n_bad++; $display("FAIL rep0_done got %b exp %b", cap_don, SGL_DON); end
    endtask

    task automatic test_start_ignored();
        fire(4'b1011, 4'd1);
        for (int i = 0; i < IG_N; i++) begin
            if (i == 1) begin
                start  = 1'b1;
                pat_in = 4'b0000;
                rep_in = 4'd5;
            end
            if (i == IG_HOLD + 1) start = 1'b0;
            capture(i, 1);
        end
        n_cmp++; if (cap_out !== IG_OUT) begin n_bad++; $display("FAIL ignore_out got %b exp %b", cap_out, IG_OUT); end
        n_cmp++; if (cap_bsy !== IG_BSY) begin n_bad++; $display("FAIL ignore_busy got %b exp %b", cap_bsy, IG_BSY); end
        n_cmp++; if (cap_don !== IG_DON) begin n_bad++; $display("FAIL ignore_done got %b exp %b", cap_don, IG_DON); end
    endtask

    task automatic test_back_to_back();
        fire(4'b1011, 4'd1);
        start = 1'b1;
        capture(0, BB_N - 2);
        start = 1'b0;
        capture(BB_N - 2, 2);
        n_cmp++; if (cap_out !== BB_OUT) begin n_bad++; $display("FAIL b2b_out got %b exp %b", cap_out, BB_OUT); end
        n_cmp++; if (cap_don !== BB_DON) begin n_bad++; $display("FAIL b2b_done got %b exp %b", cap_don, BB_DON); end
    endtask

    task automatic test_reset_mid_burst();
        fire(4'b1011, 4'd2);
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before got %b exp 1", busy); end
        rst = 1'b1;
        tick();
        n_cmp++; if ({out, valid, busy, done} !== 4'b0000) begin
            n_bad++; $display("FAIL midrst_after got %b exp 0000", {out, valid, busy, done});
        end
        rst = 1'b0;
        tick();
        n_cmp++; if ({out, valid, busy, done} !== 4'b0000) begin
            n_bad++; $display("FAIL midrst_no_done got %b exp 0000", {out, valid, busy, done});
        end
        fire(4'b0110, 4'd1);
        capture(0, SGL_N);
        n_cmp++; if (cap_out !== RN_OUT) begin n_bad++; $display("FAIL midrst_new_out got %b exp %b", cap_out, RN_OUT); end
        n_cmp++; if (cap_val !== RN_VAL) begin n_bad++; $display("FAIL midrst_new_valid got %b exp %b", cap_val, RN_VAL); end
        n_cmp++; if (cap_don !== RN_DON) begin n_bad++; $display("FAIL midrst_new_done got %b exp %b", cap_don, RN_DON); end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        pat_in = 4'b0000;
        rep_in = 4'd0;
        test_reset();
        test_single();
        test_rep2_detect();
        test_rep_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_burst();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
